// File: rtl/spi_flash_pkg.sv
// Shared opcodes, widths and FSM state encoding for the boot-flash reader.
package spi_flash_pkg;

  localparam int ADDR_W = 24;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_WRITE_EN  = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_HOLD,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/spi_sck_gen.sv
// Mode-0 SCK generator: toggles every CLK_DIV clocks while run is high and
// parks low (counter cleared) whenever run drops.
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             tick;

  // rise/fall mark the clock edge at which the registered SCK changes level
  assign tick = run && (cnt == CNT_W'(CLK_DIV - 1));
  assign rise = tick && !sck;
  assign fall = tick && sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// Streams a byte range out of the boot SPI flash (READ, or FAST_READ when
// SPI_FLASH_READER_FAST_READ_EN is defined); yields the pins to the FT2232.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 16,
  parameter int CS_IDLE = 4
) (
  input  logic              i_CLK,
  input  logic              i_RST_N,
  input  logic              i_START,
  input  logic [ADDR_W-1:0] i_ADDR,
  input  logic [LEN_W-1:0]  i_LEN,
  output logic              o_BUSY,
  output logic [7:0]        o_DATA,
  output logic              o_VALID,
  input  logic              i_READY,
  output logic              o_DONE,
  output logic              o_ABORT,
  input  logic              i_FT_CS,
  input  logic              i_SPI_MISO,
  output logic              o_SPI_CLK,
  output logic              o_SPI_MOSI,
  output logic              o_SPI_CS,
  output logic              o_SPI_OE
);

`ifdef SPI_FLASH_READER_FAST_READ_EN
  localparam logic [7:0] OPCODE = OP_FAST_READ;
`else
  localparam logic [7:0] OPCODE = OP_READ;
`endif

  localparam int CS_W = $clog2(CS_IDLE + 1);

  state_t state, state_next;

  logic [1:0]       ft_sync;
  logic             ft_cs;
  logic             run, rise, fall, sck;
  logic [31:0]      shift_out;
  logic [7:0]       shift_in, pend, data_q;
  logic [4:0]       bit_cnt;
  logic [LEN_W-1:0] rem;
  logic [CS_W-1:0]  cs_cnt;
  logic             pend_v, valid_q, busy_q, done_q, abort_q, cs_q, oe_q;
  logic             abort_now, accept, byte_done, last_byte, drained, cs_ok, slot_busy;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk  (i_CLK),
    .rst_n(i_RST_N),
    .run  (run),
    .sck  (sck),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) ft_sync <= 2'b11;
    else          ft_sync <= {ft_sync[0], i_FT_CS};
  end

  assign ft_cs     = ft_sync[1];
  assign abort_now = (state != ST_IDLE) && !ft_cs;
  assign accept    = valid_q && i_READY;
  assign slot_busy = valid_q && !i_READY;
  assign byte_done = (state == ST_DATA) && fall && (bit_cnt == 5'd8);
  assign last_byte = (rem == LEN_W'(1));
  assign drained   = !pend_v && (!valid_q || i_READY);
  assign cs_ok     = (cs_cnt >= CS_W'(CS_IDLE - 1));
  assign run       = ft_cs && ((state == ST_CMD) || (state == ST_ADDR) ||
                               (state == ST_DUMMY) || (state == ST_DATA));

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Header phases advance on the last rising edge; data bytes complete on the
  // following falling edge so SCK is always low when it parks or CS rises.
  always_comb begin
    state_next = state;
    if (abort_now) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (i_START && ft_cs && (i_LEN != '0)) state_next = ST_CMD;
        ST_CMD:    if (rise && (bit_cnt == 5'd7)) state_next = ST_ADDR;
`ifdef SPI_FLASH_READER_FAST_READ_EN
        ST_ADDR:   if (rise && (bit_cnt == 5'd23)) state_next = ST_DUMMY;
`else
        ST_ADDR:   if (rise && (bit_cnt == 5'd23)) state_next = ST_DATA;
`endif
        ST_DUMMY:  if (rise && (bit_cnt == 5'd7)) state_next = ST_DATA;
        ST_DATA:   if (byte_done) state_next = last_byte ? ST_FINISH :
                                               (slot_busy ? ST_HOLD : ST_DATA);
        ST_HOLD:   if (accept) state_next = ST_DATA;
        ST_FINISH: if (cs_ok && drained) state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      cs_q      <= 1'b1;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      shift_out <= '0;
      shift_in  <= '0;
      pend      <= '0;
      pend_v    <= 1'b0;
      bit_cnt   <= '0;
      rem       <= '0;
      cs_cnt    <= '0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      if (abort_now) begin
        cs_q      <= 1'b1;
        oe_q      <= 1'b0;
        busy_q    <= 1'b0;
        valid_q   <= 1'b0;
        pend_v    <= 1'b0;
        shift_out <= '0;
        abort_q   <= 1'b1;
      end else if (state == ST_IDLE) begin
        if (i_START && ft_cs) begin
          if (i_LEN == '0) begin
            done_q <= 1'b1;
          end else begin
            busy_q    <= 1'b1;
            oe_q      <= 1'b1;
            cs_q      <= 1'b0;
            shift_out <= {OPCODE, i_ADDR};
            rem       <= i_LEN;
            bit_cnt   <= '0;
          end
        end
      end else begin
        if (fall) shift_out <= {shift_out[30:0], 1'b0};
        if (rise && (state == ST_DATA)) shift_in <= {shift_in[6:0], i_SPI_MISO};

        if ((state_next != state) || byte_done) bit_cnt <= '0;
        else if (rise)                          bit_cnt <= bit_cnt + 5'd1;

        // A second finished byte waits in pend while the first is unaccepted
        if (byte_done) begin
          rem <= rem - LEN_W'(1);
          if (slot_busy) begin
            pend   <= shift_in;
            pend_v <= 1'b1;
          end else begin
            data_q  <= shift_in;
            valid_q <= 1'b1;
          end
        end else if (accept) begin
          if (pend_v) begin
            data_q <= pend;
            pend_v <= 1'b0;
          end else begin
            valid_q <= 1'b0;
          end
        end

        if ((state_next == ST_FINISH) && (state != ST_FINISH)) begin
          cs_q   <= 1'b1;
          cs_cnt <= '0;
        end else if ((state == ST_FINISH) && !cs_ok) begin
          cs_cnt <= cs_cnt + CS_W'(1);
        end

        if ((state == ST_FINISH) && (state_next == ST_IDLE)) begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          oe_q   <= 1'b0;
        end
      end
    end
  end

  assign o_BUSY     = busy_q;
  assign o_DATA     = data_q;
  assign o_VALID    = valid_q;
  assign o_DONE     = done_q;
  assign o_ABORT    = abort_q;
  assign o_SPI_CLK  = sck;
  assign o_SPI_MOSI = shift_out[31];
  assign o_SPI_CS   = cs_q;
  assign o_SPI_OE   = oe_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural SPI flash, byte scoreboard and
// directed scenarios (read, backpressure, zero length, abort, async reset).
module tb_spi_flash_reader;

  localparam int CLK_DIV = 2;
  localparam int LEN_W   = 16;
  localparam int CS_IDLE = 4;
`ifdef SPI_FLASH_READER_FAST_READ_EN
  localparam int         HDR_BITS = 40;
  localparam logic [7:0] EXP_OP   = 8'h0B;
  localparam int         RISES_4B = 72;
`else
  localparam int         HDR_BITS = 32;
  localparam logic [7:0] EXP_OP   = 8'h03;
  localparam int         RISES_4B = 64;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [23:0]      addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             ready = 1'b0;
  logic             ft_cs = 1'b1;
  logic             miso = 1'b0;
  logic             o_BUSY, o_VALID, o_DONE, o_ABORT;
  logic [7:0]       o_DATA;
  logic             o_SPI_CLK, o_SPI_MOSI, o_SPI_CS, o_SPI_OE;

  spi_flash_reader #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W), .CS_IDLE(CS_IDLE)) dut (
    .i_CLK     (clk),
    .i_RST_N   (rst_n),
    .i_START   (start),
    .i_ADDR    (addr),
    .i_LEN     (len),
    .o_BUSY    (o_BUSY),
    .o_DATA    (o_DATA),
    .o_VALID   (o_VALID),
    .i_READY   (ready),
    .o_DONE    (o_DONE),
    .o_ABORT   (o_ABORT),
    .i_FT_CS   (ft_cs),
    .i_SPI_MISO(miso),
    .o_SPI_CLK (o_SPI_CLK),
    .o_SPI_MOSI(o_SPI_MOSI),
    .o_SPI_CS  (o_SPI_CS),
    .o_SPI_OE  (o_SPI_OE)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: event not seen, required within cycle budget", name);
  endtask

  function automatic logic [7:0] byte_at(logic [23:0] a);
    case (a)
      24'h001000: return 8'hDE;
      24'h001001: return 8'hAD;
      24'h001002: return 8'hBE;
      24'h001003: return 8'hEF;
      default:    return a[7:0] ^ 8'h5A ^ {a[11:8], a[15:12]};
    endcase
  endfunction

  // Flash model: header captured on SCK rise, data shifted out on SCK fall
  int          rise_n = 0;
  logic [7:0]  cmd_rx = '0;
  logic [23:0] addr_rx = '0;

  always @(negedge o_SPI_CS) rise_n = 0;
  always @(posedge o_SPI_CS) miso = 1'b0;

  always @(posedge o_SPI_CLK) begin
    if (!o_SPI_CS) begin
      if (rise_n < 8)       cmd_rx  = {cmd_rx[6:0], o_SPI_MOSI};
      else if (rise_n < 32) addr_rx = {addr_rx[22:0], o_SPI_MOSI};
      rise_n++;
    end
  end

  always @(negedge o_SPI_CLK) begin
    int         k;
    logic [7:0] b;
    if (!o_SPI_CS && rise_n >= HDR_BITS) begin
      k    = rise_n - HDR_BITS;
      b    = byte_at(addr_rx + 24'(k / 8));
      miso = b[7 - (k % 8)];
    end
  end

  // Scoreboard and event counters, sampled mid-cycle
  logic [7:0] exp_q[$];
  logic [7:0] rx[$];
  int done_cnt = 0, abort_cnt = 0, cs_hi_run = 0, cs_hi_at_done = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_DONE) begin
        done_cnt++;
        cs_hi_at_done = cs_hi_run;
      end
      if (o_ABORT) abort_cnt++;
      cs_hi_run = o_SPI_CS ? cs_hi_run + 1 : 0;
      if (o_VALID && ready) begin
        rx.push_back(o_DATA);
        if (exp_q.size() == 0) fail_now("unexpected_byte");
        else                   check_output("stream_byte", o_DATA, exp_q.pop_front());
      end
    end
  end

  task automatic apply_stimulus(logic [23:0] a, int n);
    @(posedge clk);
    #1;
    addr  = a;
    len   = LEN_W'(n);
    start = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back(byte_at(a + 24'(i)));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(int d0, int budget, string name);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == d0) fail_now(name);
  endtask

  task automatic check_reset_values(string tag);
    check_output({tag, "_cs"},    o_SPI_CS,   1);
    check_output({tag, "_sck"},   o_SPI_CLK,  0);
    check_output({tag, "_mosi"},  o_SPI_MOSI, 0);
    check_output({tag, "_oe"},    o_SPI_OE,   0);
    check_output({tag, "_busy"},  o_BUSY,     0);
    check_output({tag, "_valid"}, o_VALID,    0);
    check_output({tag, "_data"},  o_DATA,     0);
    check_output({tag, "_done"},  o_DONE,     0);
    check_output({tag, "_abort"}, o_ABORT,    0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, required under 50000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0, a0, r0, hi, n;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Plain 4-byte read with the consumer always ready
    ready = 1'b1;
    rx.delete();
    d0 = done_cnt;
    apply_stimulus(24'h001000, 4);
    check_output("start_busy", o_BUSY, 1);
    check_output("start_cs", o_SPI_CS, 0);
    check_output("start_oe", o_SPI_OE, 1);
    wait_done(d0, 2000, "main_done");
    repeat (2) @(posedge clk);
    #1;
    check_output("main_count", rx.size(), 4);
    if (rx.size() == 4) begin
      check_output("main_b0", rx[0], 8'hDE);
      check_output("main_b1", rx[1], 8'hAD);
      check_output("main_b2", rx[2], 8'hBE);
      check_output("main_b3", rx[3], 8'hEF);
    end
    check_output("main_opcode", cmd_rx, EXP_OP);
    check_output("main_addr", addr_rx, 24'h001000);
    check_output("main_rises", rise_n, RISES_4B);
    check_output("main_done_once", done_cnt - d0, 1);
    check_output("main_cs_gap", cs_hi_at_done >= CS_IDLE, 1);
    check_output("main_drained", exp_q.size(), 0);
    check_output("main_idle_oe", o_SPI_OE, 0);
    check_output("main_idle_busy", o_BUSY, 0);

    // Backpressure: consumer stalls after the first byte appears
    ready = 1'b0;
    rx.delete();
    d0 = done_cnt;
    apply_stimulus(24'h000200, 3);
    n = 0;
    while (!o_VALID && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!o_VALID) fail_now("bp_first_valid");
    r0 = rise_n;
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i >= 35 && o_SPI_CLK) hi++;
    end
    check_output("bp_rises_in_stall", rise_n - r0, 8);
    check_output("bp_sck_parked", hi, 0);
    check_output("bp_cs_held", o_SPI_CS, 0);
    check_output("bp_busy", o_BUSY, 1);
    check_output("bp_valid", o_VALID, 1);
    check_output("bp_hold_data", o_DATA, byte_at(24'h000200));
    @(posedge clk);
    #1 ready = 1'b1;
    wait_done(d0, 2000, "bp_done");
    repeat (2) @(posedge clk);
    #1;
    check_output("bp_count", rx.size(), 3);
    check_output("bp_drained", exp_q.size(), 0);
    check_output("bp_rises", rise_n, HDR_BITS + 24);

    // Zero length: done pulse only, bus untouched
    d0 = done_cnt;
    apply_stimulus(24'h000055, 0);
    check_output("zero_done", o_DONE, 1);
    check_output("zero_cs", o_SPI_CS, 1);
    check_output("zero_oe", o_SPI_OE, 0);
    check_output("zero_busy", o_BUSY, 0);
    @(posedge clk);
    #1;
    check_output("zero_done_clear", o_DONE, 0);
    check_output("zero_cs_after", o_SPI_CS, 1);
    repeat (2) @(posedge clk);
    check_output("zero_done_once", done_cnt - d0, 1);

    // Programmer grabs the flash during the second data byte
    ready = 1'b1;
    rx.delete();
    d0 = done_cnt;
    a0 = abort_cnt;
    apply_stimulus(24'h000300, 4);
    n = 0;
    while (rx.size() == 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (rx.size() == 0) fail_now("abort_first_byte");
    repeat (4) @(posedge clk);
    #1 ft_cs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("abort_cs", o_SPI_CS, 1);
    check_output("abort_oe", o_SPI_OE, 0);
    check_output("abort_sck", o_SPI_CLK, 0);
    check_output("abort_valid", o_VALID, 0);
    check_output("abort_busy", o_BUSY, 0);
    check_output("abort_pulse", o_ABORT, 1);
    repeat (2) @(posedge clk);
    #1;
    check_output("abort_once", abort_cnt - a0, 1);
    check_output("abort_no_done", done_cnt - d0, 0);
    check_output("abort_bytes", rx.size(), 1);
    exp_q.delete();
    ft_cs = 1'b1;
    repeat (5) @(posedge clk);
    d0 = done_cnt;
    apply_stimulus(24'h000000, 2);
    wait_done(d0, 2000, "post_abort_done");
    repeat (2) @(posedge clk);
    #1;
    check_output("post_abort_count", rx.size(), 3);
    check_output("post_abort_drained", exp_q.size(), 0);
    check_output("post_abort_addr", addr_rx, 24'h000000);

    // Asynchronous reset in the middle of the address phase
    d0 = done_cnt;
    apply_stimulus(24'h001000, 4);
    n = 0;
    while (rise_n < 12 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (rise_n < 12) fail_now("rst_reach_addr");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    check_output("async_rst_no_done", done_cnt - d0, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    rx.delete();
    d0 = done_cnt;
    apply_stimulus(24'h001000, 4);
    wait_done(d0, 2000, "recover_done");
    repeat (2) @(posedge clk);
    #1;
    check_output("recover_count", rx.size(), 4);
    check_output("recover_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
